// File: rtl/ssd_pkg.sv
// Shared definitions for the 7-segment scan decoder: glyph codes, the blank
// pattern and the frame-collection state encoding.
package ssd_pkg;

    // Active-low segment codes, bit6..bit0 = g,f,e,d,c,b,a
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    // All segments off, and all anodes off
    localparam logic [6:0] BLANK_SEG   = 7'h7F;
    localparam logic [3:0] ANODE_BLANK = 4'hF;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } scan_state_t;

    // Map a single active (high after inversion) anode bit to its digit index
    function automatic logic [1:0] anode_to_idx(input logic [3:0] an_low);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (an_low[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// Bundle of the scanned display lines and the decoder's result outputs.
// The master side drives the display lines and observes the results; the
// slave side is the decoder itself.
interface ssd_scan_decoder_if;

    logic [3:0]  Anode;
    logic [6:0]  ssd_out;
    logic        digit_strobe;
    logic [1:0]  digit_idx;
    logic [3:0]  digit_val;
    logic [3:0]  digit_seen;
    logic        frame_valid;
    logic [15:0] frame_value;
    logic        seg_err;
    logic        anode_err;
    logic        timeout;

    modport master (
        output Anode, ssd_out,
        input  digit_strobe, digit_idx, digit_val, digit_seen,
               frame_valid, frame_value, seg_err, anode_err, timeout
    );

    modport slave (
        input  Anode, ssd_out,
        output digit_strobe, digit_idx, digit_val, digit_seen,
               frame_valid, frame_value, seg_err, anode_err, timeout
    );

endinterface

// File: rtl/ssd_scan_decoder_seg7_to_hex.sv
// Combinational reverse lookup from an active-low segment pattern to the hex
// nibble it displays; valid drops for any pattern that is not a hex glyph.
module seg7_to_hex
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       valid
);

    // Glyph table lookup, unknown patterns flagged invalid
    always_comb begin
        value = 4'h0;
        valid = 1'b1;
        case (seg)
            GLYPH_0: value = 4'h0;
            GLYPH_1: value = 4'h1;
            GLYPH_2: value = 4'h2;
            GLYPH_3: value = 4'h3;
            GLYPH_4: value = 4'h4;
            GLYPH_5: value = 4'h5;
            GLYPH_6: value = 4'h6;
            GLYPH_7: value = 4'h7;
            GLYPH_8: value = 4'h8;
            GLYPH_9: value = 4'h9;
            GLYPH_A: value = 4'hA;
            GLYPH_B: value = 4'hB;
            GLYPH_C: value = 4'hC;
            GLYPH_D: value = 4'hD;
            GLYPH_E: value = 4'hE;
            GLYPH_F: value = 4'hF;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Display-scan monitor: samples the multiplexed anode/segment lines, waits for
// each digit to dwell stably, decodes it and assembles the 4-digit value.
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
)
(
    input  logic clk,
    input  logic rst,
    ssd_scan_decoder_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX   = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [10:0]      smp;
    logic [10:0]      prev;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    scan_state_t state_q;
    scan_state_t state_d;

    logic [3:0]  an_low;
    logic        an_one;
    logic        an_blank;
    logic [1:0]  cap_idx;
    logic [3:0]  glyph_val;
    logic        glyph_ok;
    logic        capture;
    logic        valid_cap;
    logic        bad_cap;
    logic        an_err_evt;
    logic        frame_done;
    logic        timeout_evt;

    logic        strobe_q;
    logic [1:0]  idx_q;
    logic [3:0]  val_q;
    logic [3:0]  seen_q;
    logic        frame_valid_q;
    logic [15:0] frame_value_q;
    logic        seg_err_q;
    logic        anode_err_q;
    logic        timeout_q;
    logic [3:0]  slot [4];

    // Register the raw display lines and keep the previous sample for comparison
    always_ff @(posedge clk) begin
        if (rst) begin
            smp  <= {ANODE_BLANK, BLANK_SEG};
            prev <= {ANODE_BLANK, BLANK_SEG};
        end else begin
            smp  <= {bus.Anode, bus.ssd_out};
            prev <= smp;
        end
    end

    // Count consecutive identical samples, saturating so a dwell captures once
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (smp == prev) begin
            if (settle_cnt != SETTLE_MAX) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end else begin
            settle_cnt <= '0;
        end
    end

    assign an_low   = ~smp[10:7];
    assign an_one   = $onehot(an_low);
    assign an_blank = (an_low == 4'h0);
    assign cap_idx  = anode_to_idx(an_low);

    seg7_to_hex u_seg7_to_hex (
        .seg   (smp[6:0]),
        .value (glyph_val),
        .valid (glyph_ok)
    );

    // The capture fires on the edge where the settle counter reaches its limit
    assign capture    = (smp == prev) && (settle_cnt == SETTLE_LAST);
    assign valid_cap  = capture && an_one && glyph_ok;
    assign bad_cap    = capture && an_one && !glyph_ok;
    assign an_err_evt = capture && !an_one && !an_blank;

    // Frame state: completion has priority, a capture beats a pending timeout
    always_comb begin
        state_d     = state_q;
        frame_done  = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_cap) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (seen_q == 4'hF) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end else if (!valid_cap && (timeout_cnt == TIMEOUT_LAST)) begin
                    timeout_evt = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Cycles spent collecting since the last good digit
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if ((state_q != COLLECT) || valid_cap || frame_done || timeout_evt) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // Digit slots, seen mask, result registers and single-cycle event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q      <= 1'b0;
            idx_q         <= 2'd0;
            val_q         <= 4'h0;
            seen_q        <= 4'h0;
            frame_valid_q <= 1'b0;
            frame_value_q <= 16'h0;
            seg_err_q     <= 1'b0;
            anode_err_q   <= 1'b0;
            timeout_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot[i] <= 4'h0;
            end
        end else begin
            strobe_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            anode_err_q   <= 1'b0;
            timeout_q     <= 1'b0;
            if (valid_cap) begin
                strobe_q        <= 1'b1;
                idx_q           <= cap_idx;
                val_q           <= glyph_val;
                slot[cap_idx]   <= glyph_val;
                seen_q[cap_idx] <= 1'b1;
            end
            if (bad_cap) begin
                seg_err_q       <= 1'b1;
                seen_q[cap_idx] <= 1'b0;
            end
            if (an_err_evt) begin
                anode_err_q <= 1'b1;
            end
            if (frame_done) begin
                frame_valid_q <= 1'b1;
                frame_value_q <= {slot[3], slot[2], slot[1], slot[0]};
                seen_q        <= 4'h0;
            end
            if (timeout_evt) begin
                timeout_q <= 1'b1;
                seen_q    <= 4'h0;
            end
        end
    end

    assign bus.digit_strobe = strobe_q;
    assign bus.digit_idx    = idx_q;
    assign bus.digit_val    = val_q;
    assign bus.digit_seen   = seen_q;
    assign bus.frame_valid  = frame_valid_q;
    assign bus.frame_value  = frame_value_q;
    assign bus.seg_err      = seg_err_q;
    assign bus.anode_err    = anode_err_q;
    assign bus.timeout      = timeout_q;

endmodule
